// File: rtl/serial_frame_sched_pkg.sv
// serial_sched_pkg: shared types and register map for serial_frame_sched.
package serial_sched_pkg;

   // Scheduler FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      GAP   = 2'd3
   } sched_state_e;

   // Register indices, selected by ADR_I[3:2]
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_DIV    = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;

   // STATUS field positions
   localparam int ST_EMPTY_BIT = 0;
   localparam int ST_FULL_BIT  = 1;
   localparam int ST_COUNT_LSB = 2;
   localparam int ST_COUNT_W   = 3;
   localparam int ST_OVF_BIT   = 5;

endpackage

// File: rtl/serial_frame_sched_fifo.sv
// frame_fifo: synchronous frame FIFO; push while full and pop while empty
// are ignored. Same-clock push and pop keep the count unchanged.
module frame_fifo #(
   parameter int W     = 10,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  din_i,
   output logic [W-1:0]  dout_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Storage array; contents are don't-care while empty, so no reset
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   // Pointers and occupancy
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/serial_frame_sched.sv
// serial_frame_sched: Wishbone classic slave feeding a frame FIFO, drained
// LSB-first onto a serial line at DIV+1 clocks per bit with idle gaps.
// Optional feature macro: SERIAL_PARITY_EN appends an even-parity bit.
// GAP_BITS must be at least 1.
module serial_frame_sched
   import serial_sched_pkg::*;
#(
   parameter int          FRAME_W    = 10,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] DIV_RST    = 16'd3,
   parameter int          GAP_BITS   = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        CYC_I,
   input  logic        STB_I,
   input  logic        WE_I,
   input  logic [31:0] ADR_I,
   input  logic [31:0] DAT_I,
   output logic [31:0] DAT_O,
   output logic        ACK_O,
   output logic        data_o,
   output logic        ena_o,
   output logic        busy_o
);

   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam int FBW = $clog2(FRAME_W + 2);
   localparam int GBW = $clog2(GAP_BITS + 1);
   localparam int BCW = (FBW > GBW) ? FBW : GBW;
`ifdef SERIAL_PARITY_EN
   localparam int SH_W = FRAME_W + 1;
`else
   localparam int SH_W = FRAME_W;
`endif
   localparam logic [BCW-1:0] LAST_BIT = BCW'(SH_W - 1);
   localparam logic [BCW-1:0] LAST_GAP = BCW'(GAP_BITS - 1);

   // Bus side
   logic         wb_req, ack_q, ovf_q;
   logic [1:0]   reg_sel;
   logic [31:0]  rd_data, dat_q;
   logic [15:0]  div_q;
   logic         fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [FRAME_W-1:0] fifo_dout;
   logic [CW-1:0]      fifo_count;

   // Line side
   sched_state_e state_q;
   logic [SH_W-1:0] shreg_q, load_word;
   logic [15:0]     timer_q, div_lat_q;
   logic [BCW-1:0]  bitcnt_q;
   logic            data_q, ena_q, busy_q;

   logic unused_bits;
   assign unused_bits = ^{ADR_I[31:4], ADR_I[1:0], DAT_I[31:16]};

   // A new transaction is one not already being acked this clock
   assign wb_req    = CYC_I && STB_I && !ack_q;
   assign reg_sel   = ADR_I[3:2];
   assign fifo_push = wb_req && WE_I && (reg_sel == REG_DATA);
   assign fifo_pop  = (state_q == LOAD);

`ifdef SERIAL_PARITY_EN
   assign load_word = {^fifo_dout, fifo_dout};
`else
   assign load_word = fifo_dout;
`endif

   assign ACK_O  = ack_q;
   assign DAT_O  = dat_q;
   assign data_o = data_q;
   assign ena_o  = ena_q;
   assign busy_o = busy_q;

   frame_fifo #(.W(FRAME_W), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .din_i   (DAT_I[FRAME_W-1:0]),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Register read mux
   always_comb begin
      rd_data = '0;
      case (reg_sel)
         REG_DIV: rd_data[15:0] = div_q;
         REG_STATUS: begin
            rd_data[ST_EMPTY_BIT]                 = fifo_empty;
            rd_data[ST_FULL_BIT]                  = fifo_full;
            rd_data[ST_COUNT_LSB +: ST_COUNT_W]   = ST_COUNT_W'(fifo_count);
            rd_data[ST_OVF_BIT]                   = ovf_q;
         end
         default: rd_data = '0;
      endcase
   end

   // Wishbone handshake and register side effects, once per transaction
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ack_q <= 1'b0;
         dat_q <= '0;
         div_q <= DIV_RST;
         ovf_q <= 1'b0;
      end else begin
         ack_q <= wb_req;
         dat_q <= (wb_req && !WE_I) ? rd_data : '0;
         if (wb_req && WE_I && (reg_sel == REG_DIV))
            div_q <= DAT_I[15:0];
         if (fifo_push && fifo_full)
            ovf_q <= 1'b1;
         else if (wb_req && !WE_I && (reg_sel == REG_STATUS))
            ovf_q <= 1'b0;
      end
   end

   // Frame FSM: bit timer counts DIV_lat..0 per bit; bitcnt_q is reused
   // to count gap bit periods
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         timer_q   <= '0;
         div_lat_q <= '0;
         bitcnt_q  <= '0;
         data_q    <= 1'b0;
         ena_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               data_q <= 1'b0;
               ena_q  <= 1'b0;
               if (!fifo_empty) begin
                  state_q <= LOAD;
                  busy_q  <= 1'b1;
               end
            end
            LOAD: begin
               shreg_q   <= load_word;
               data_q    <= load_word[0];
               ena_q     <= 1'b1;
               timer_q   <= div_q;
               div_lat_q <= div_q;
               bitcnt_q  <= '0;
               state_q   <= SHIFT;
            end
            SHIFT: begin
               if (timer_q == 16'd0) begin
                  timer_q <= div_lat_q;
                  if (bitcnt_q == LAST_BIT) begin
                     data_q   <= 1'b0;
                     ena_q    <= 1'b0;
                     bitcnt_q <= '0;
                     state_q  <= GAP;
                  end else begin
                     shreg_q  <= shreg_q >> 1;
                     data_q   <= shreg_q[1];
                     ena_q    <= 1'b1;
                     bitcnt_q <= bitcnt_q + BCW'(1);
                  end
               end else begin
                  timer_q <= timer_q - 16'd1;
                  ena_q   <= 1'b0;
               end
            end
            GAP: begin
               data_q <= 1'b0;
               ena_q  <= 1'b0;
               if (timer_q == 16'd0) begin
                  timer_q <= div_lat_q;
                  if (bitcnt_q == LAST_GAP) begin
                     bitcnt_q <= '0;
                     if (!fifo_empty) begin
                        state_q <= LOAD;
                     end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                     end
                  end else begin
                     bitcnt_q <= bitcnt_q + BCW'(1);
                  end
               end else begin
                  timer_q <= timer_q - 16'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
